// File: rtl/regbank_arbiter.sv
// -----------------------------------------------------------------------------
// regbank_arbiter
//
// Owns the 8-byte peripheral register bank and arbitrates access to it from
// two masters:
//   * Port A (I2C slave application side) issues one-cycle strobes that cannot
//     be stalled. One access is buffered in a pending slot until it is granted.
//   * Port B (local dice/display logic) uses a req/ack handshake.
// At most one bank access completes per clock. Ties go round-robin.
//
// Handshake semantics (both ports):
//   Port A: a_wen/a_ren are single-cycle strobes sampled at the rising edge.
//           a_wen wins if both are high. The access completes with a one-cycle
//           a_rvalid pulse; a_rdata is valid only while a_rvalid=1 (a write
//           returns the written data).
//   Port B: b_req is raised with b_we/b_addr/b_wdata stable and held until
//           b_ack. b_ack is a one-cycle pulse; b_rdata is valid only while
//           b_ack=1. The b_ack cycle is never re-granted, so the requester may
//           drop b_req during or one cycle after the b_ack cycle.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   a_wen, a_ren        port A write/read strobes
//   a_addr, a_wdata     port A address / write data
//   a_rvalid, a_rdata   port A completion pulse / read data
//   a_overflow          sticky: a port A strobe was dropped
//   clr_ovf             clears a_overflow (a new drop in the same cycle wins)
//   b_req, b_we         port B request / write-not-read
//   b_addr, b_wdata     port B address / write data
//   b_ack, b_rdata      port B completion pulse / read data
//   bank_q              flat view of the bank, byte n at [8n+7:8n]
// -----------------------------------------------------------------------------
module regbank_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_wen,
    input  logic        a_ren,
    input  logic [2:0]  a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_rvalid,
    output logic [7:0]  a_rdata,
    output logic        a_overflow,
    input  logic        clr_ovf,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [2:0]  b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic [7:0]  b_rdata,
    output logic [63:0] bank_q
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [7:0] bank [8];

    // Port A pending slot
    logic       pend_v;
    logic       pend_we;
    logic [2:0] pend_addr;
    logic [7:0] pend_wdata;

    // 1 = port B received the most recent grant. Resets to B so that A wins
    // the first tie.
    logic       last_grant_b;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic       a_strobe;
    logic       b_elig;
    logic       grant_a;
    logic       grant_b;
    logic       a_capture;
    logic       a_drop;

    // Shared access path: only one port is granted per edge, so a single
    // read/write datapath is muxed between the two.
    logic       acc_we;
    logic [2:0] acc_addr;
    logic [7:0] acc_wdata;
    logic [7:0] acc_result;

    always_comb begin
        a_strobe = a_wen | a_ren;

        // b_ack high means this request was just serviced; masking it lets the
        // requester drop b_req one cycle late without a duplicate access.
        b_elig   = b_req & ~b_ack;

        grant_a  = pend_v & (~b_elig | last_grant_b);
        grant_b  = b_elig & (~pend_v | ~last_grant_b);

        // The slot is free if empty or being drained at this very edge, which
        // makes back-to-back strobes lossless.
        a_capture = a_strobe & (~pend_v | grant_a);
        a_drop    = a_strobe & pend_v & ~grant_a;

        acc_we    = 1'b0;
        acc_addr  = 3'd0;
        acc_wdata = 8'h00;
        if (grant_a) begin
            acc_we    = pend_we;
            acc_addr  = pend_addr;
            acc_wdata = pend_wdata;
        end else if (grant_b) begin
            acc_we    = b_we;
            acc_addr  = b_addr;
            acc_wdata = b_wdata;
        end

        // Reads return the bank contents before this edge's write; writes
        // echo their own data.
        acc_result = acc_we ? acc_wdata : bank[acc_addr];
    end

    // -------------------------------------------------------------------------
    // Sequential
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                bank[i] <= 8'h00;
            end
            pend_v       <= 1'b0;
            pend_we      <= 1'b0;
            pend_addr    <= 3'd0;
            pend_wdata   <= 8'h00;
            last_grant_b <= 1'b1;
            a_rvalid     <= 1'b0;
            a_rdata      <= 8'h00;
            b_ack        <= 1'b0;
            b_rdata      <= 8'h00;
            a_overflow   <= 1'b0;
        end else begin
            // Bank write
            if ((grant_a | grant_b) && acc_we) begin
                bank[acc_addr] <= acc_wdata;
            end

            // Completion pulses
            a_rvalid <= grant_a;
            b_ack    <= grant_b;
            if (grant_a) begin
                a_rdata <= acc_result;
            end
            if (grant_b) begin
                b_rdata <= acc_result;
            end

            // Round-robin history
            if (grant_a) begin
                last_grant_b <= 1'b0;
            end else if (grant_b) begin
                last_grant_b <= 1'b1;
            end

            // Pending slot: capture has priority over drain so that a strobe
            // arriving on the drain edge refills the slot.
            if (a_capture) begin
                pend_v     <= 1'b1;
                pend_we    <= a_wen;
                pend_addr  <= a_addr;
                pend_wdata <= a_wdata;
            end else if (grant_a) begin
                pend_v     <= 1'b0;
            end

            // Sticky overflow: a drop in the same cycle beats clr_ovf.
            if (a_drop) begin
                a_overflow <= 1'b1;
            end else if (clr_ovf) begin
                a_overflow <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Flat export
    // -------------------------------------------------------------------------
    for (genvar n = 0; n < 8; n++) begin : g_bank_q
        assign bank_q[8*n +: 8] = bank[n];
    end

endmodule

// File: tb/tb_regbank_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for regbank_arbiter: directed scenarios followed by randomized
// concurrent traffic on both ports. A cycle-level reference model (pending
// slot as a queue, bank as an array) predicts every completion and pushes it
// into per-port expected queues; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_regbank_arbiter;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_wen, a_ren;
    logic [2:0]  a_addr;
    logic [7:0]  a_wdata;
    logic        a_rvalid;
    logic [7:0]  a_rdata;
    logic        a_overflow;
    logic        clr_ovf;
    logic        b_req, b_we;
    logic [2:0]  b_addr;
    logic [7:0]  b_wdata;
    logic        b_ack;
    logic [7:0]  b_rdata;
    logic [63:0] bank_q;

    always #5 clk = ~clk;

    regbank_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_wen      (a_wen),
        .a_ren      (a_ren),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_rvalid   (a_rvalid),
        .a_rdata    (a_rdata),
        .a_overflow (a_overflow),
        .clr_ovf    (clr_ovf),
        .b_req      (b_req),
        .b_we       (b_we),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_ack      (b_ack),
        .b_rdata    (b_rdata),
        .bank_q     (bank_q)
    );

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected completions: {cycle[31:0], data[7:0]}
    logic [39:0] exp_a_q[$];
    logic [39:0] exp_b_q[$];

    // -------------------------------------------------------------------------
    // Reference model (evaluated at each rising edge from the port rules)
    // -------------------------------------------------------------------------
    int          cyc = 0;
    bit          started = 0;
    logic [7:0]  m_bank [8];
    logic [11:0] m_pend_q[$];   // {we, addr, wdata}; capacity 1
    bit          m_last_b;
    bit          m_b_ack;
    bit          m_ovf;

    always @(posedge clk) begin
        bit          b_el, a_has, ga, gb, drop;
        logic [11:0] e;
        logic [7:0]  rd;
        cyc++;
        if (!rst_n) begin
            started = 1;
            for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
            m_pend_q.delete();
            exp_a_q.delete();
            exp_b_q.delete();
            m_last_b = 1;
            m_b_ack  = 0;
            m_ovf    = 0;
        end else if (started) begin
            b_el  = b_req && !m_b_ack;
            a_has = m_pend_q.size() > 0;
            ga = a_has && (!b_el || m_last_b);
            gb = b_el && (!a_has || !m_last_b);
            if (ga) begin
                e  = m_pend_q.pop_front();
                rd = e[11] ? e[7:0] : m_bank[e[10:8]];
                if (e[11]) m_bank[e[10:8]] = e[7:0];
                exp_a_q.push_back({cyc[31:0], rd});
                m_last_b = 0;
            end
            if (gb) begin
                rd = b_we ? b_wdata : m_bank[b_addr];
                if (b_we) m_bank[b_addr] = b_wdata;
                exp_b_q.push_back({cyc[31:0], rd});
                m_last_b = 1;
            end
            m_b_ack = gb;
            drop = 0;
            if (a_wen || a_ren) begin
                if (m_pend_q.size() == 0) m_pend_q.push_back({a_wen, a_addr, a_wdata});
                else drop = 1;
            end
            if (drop) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
    end

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        bit          a_due, b_due;
        logic [63:0] flat;
        if (started) begin
            a_due = exp_a_q.size() > 0 && exp_a_q[0][39:8] == cyc[31:0];
            b_due = exp_b_q.size() > 0 && exp_b_q[0][39:8] == cyc[31:0];
            chk("a_rvalid", {63'd0, a_rvalid}, {63'd0, a_due});
            chk("b_ack", {63'd0, b_ack}, {63'd0, b_due});
            if (a_due) begin
                if (a_rvalid) chk("a_rdata", {56'd0, a_rdata}, {56'd0, exp_a_q[0][7:0]});
                void'(exp_a_q.pop_front());
            end
            if (b_due) begin
                if (b_ack) chk("b_rdata", {56'd0, b_rdata}, {56'd0, exp_b_q[0][7:0]});
                void'(exp_b_q.pop_front());
            end
            for (int i = 0; i < 8; i++) flat[8*i +: 8] = m_bank[i];
            chk("bank_q", bank_q, flat);
            chk("a_overflow", {63'd0, a_overflow}, {63'd0, m_ovf});
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic a_strobe(input logic we, input logic re, input logic [2:0] ad, input logic [7:0] wd);
        a_wen   = we;
        a_ren   = re;
        a_addr  = ad;
        a_wdata = wd;
        tick();
        a_wen   = 1'b0;
        a_ren   = 1'b0;
    endtask

    // Holds the request until b_ack; optionally keeps b_req through the ack
    // cycle to exercise the late-drop rule.
    task automatic b_access(input logic we, input logic [2:0] ad, input logic [7:0] wd, input bit late);
        bit got;
        got     = 0;
        b_req   = 1'b1;
        b_we    = we;
        b_addr  = ad;
        b_wdata = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (b_ack) got = 1;
        end
        if (!got) begin
            errors++;
            $display("FAIL b_ack_timeout: got no ack expected ack within 20 cycles (t=%0t)", $time);
        end
        if (late) tick();
        b_req = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        a_wen = 0; a_ren = 0; a_addr = 0; a_wdata = 0; clr_ovf = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        idle(2);
        chk("reset_a_rdata", {56'd0, a_rdata}, 64'd0);
        chk("reset_b_rdata", {56'd0, b_rdata}, 64'd0);
        rst_n = 1'b1;

        // A write then read of addr 2
        a_strobe(1, 0, 3'd2, 8'h5A);
        idle(3);
        chk("bank_byte2", {56'd0, bank_q[23:16]}, 64'h5A);
        a_strobe(0, 1, 3'd2, 8'h00);
        idle(3);

        // B read of addr 7, b_req held one cycle past ack
        b_access(0, 3'd7, 8'h00, 1);
        idle(2);

        // Tie: A pending while B requests; last grant was B so A goes first
        a_strobe(1, 0, 3'd0, 8'h11);
        b_access(1, 3'd0, 8'h22, 0);
        idle(3);
        chk("tie_final_byte0", {56'd0, bank_q[7:0]}, 64'h22);

        // Make A the last grant, then B wins the tie and a second A strobe drops
        a_strobe(1, 0, 3'd5, 8'h33);
        idle(3);
        a_strobe(1, 0, 3'd6, 8'h44);
        fork
            b_access(1, 3'd6, 8'h55, 0);
            a_strobe(1, 0, 3'd7, 8'h66);
        join
        idle(4);
        chk("overflow_set", {63'd0, a_overflow}, 64'd1);
        chk("lost_write_byte7", {56'd0, bank_q[63:56]}, 64'h00);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("overflow_cleared", {63'd0, a_overflow}, 64'd0);

        // Same pattern with clr_ovf coincident with the drop: set wins
        a_strobe(1, 0, 3'd1, 8'h77);
        fork
            b_access(1, 3'd1, 8'h88, 0);
            begin
                clr_ovf = 1'b1;
                a_strobe(1, 0, 3'd3, 8'h99);
                clr_ovf = 1'b0;
            end
        join
        idle(4);
        chk("overflow_set_beats_clr", {63'd0, a_overflow}, 64'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // Eight back-to-back A strobes, B idle
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) a_strobe(1, 0, 3'd4, 8'(8'hA0 + i));
            else            a_strobe(0, 1, 3'd4, 8'h00);
        end
        idle(3);
        chk("no_overflow_streaming", {63'd0, a_overflow}, 64'd0);

        // Reset with A pending and B requesting
        a_strobe(1, 0, 3'd3, 8'hC3);
        rst_n   = 1'b0;
        b_req   = 1'b1;
        b_we    = 1'b0;
        b_addr  = 3'd3;
        tick();
        chk("rst_mid_a_rvalid", {63'd0, a_rvalid}, 64'd0);
        chk("rst_mid_b_ack", {63'd0, b_ack}, 64'd0);
        chk("rst_mid_bank_q", bank_q, 64'd0);
        chk("rst_mid_a_rdata", {56'd0, a_rdata}, 64'd0);
        chk("rst_mid_b_rdata", {56'd0, b_rdata}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("b_ack_after_reset", {63'd0, b_ack}, 64'd1);
        b_req = 1'b0;
        idle(2);

        // Randomized concurrent traffic
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 9) < 6) begin
                        a_wen = 1'($urandom_range(0, 1));
                        a_ren = 1'($urandom_range(0, 1));
                        if (!a_wen && !a_ren) a_ren = 1'b1;
                    end
                    a_addr  = 3'($urandom_range(0, 7));
                    a_wdata = 8'($urandom_range(0, 255));
                    clr_ovf = ($urandom_range(0, 9) == 0);
                    tick();
                    a_wen   = 1'b0;
                    a_ren   = 1'b0;
                    clr_ovf = 1'b0;
                end
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    idle($urandom_range(0, 3));
                    b_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                end
            end
        join
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regbank_arbiter.md
# regbank_arbiter

Two-port arbiter and register bank owning the 8-byte peripheral register space. It sequences accesses from the I2C slave application interface (port A) and the local dice/display logic (port B). Port A issues single-cycle strobes that cannot be stalled, so the block buffers one pending A access. Port B uses a req/ack handshake. At most one bank access completes per clock, with round-robin arbitration. All eight bytes are exported flat for the PWM and GPIO consumers.

## Interface
Parameters: none.

- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low; clock clk
- a_wen  in  1  port A write strobe, one cycle wide
- a_ren  in  1  port A read strobe, one cycle wide
- a_addr  in  3  port A byte address
- a_wdata  in  8  port A write data
- a_rvalid  out  1  port A completion pulse, one cycle wide
- a_rdata  out  8  port A read data, valid while a_rvalid=1
- a_overflow  out  1  sticky flag: a port A strobe was dropped
- clr_ovf  in  1  clears a_overflow
- b_req  in  1  port B request; b_we/b_addr/b_wdata held stable until b_ack
- b_we  in  1  port B 1=write, 0=read
- b_addr  in  3  port B byte address
- b_wdata  in  8  port B write data
- b_ack  out  1  port B completion pulse, one cycle wide
- b_rdata  out  8  port B read data, valid while b_ack=1
- bank_q  out  64  byte n at [8n+7:8n]

## Operation
- Bank: 8×8 flops, all writable.
- Pending buffer for port A: pend_v, pend_we, pend_addr, pend_wdata.
  - A strobe (a_wen|a_ren) captures the access into the buffer.
  - a_wen and a_ren in the same cycle: treated as a write; the read is ignored.
  - Strobe while pend_v=1 and the pending entry is not serviced at this edge: the strobe is dropped and a_overflow is set.
  - Strobe in the same cycle the pending entry is serviced: the new strobe is captured (back-to-back accesses are lossless).
- Port B eligibility: eligible when b_req=1 and b_ack=0. The cycle carrying b_ack is never re-granted, so the requester can drop b_req one cycle late.
- Arbitration at each rising edge:
  - Only pend_v set: grant A.
  - Only B eligible: grant B.
  - Both: grant the port not in last_grant.
  - last_grant updates on every grant.
- Access:
  - Write: bank[addr] ← wdata; returned rdata = wdata.
  - Read: rdata = bank[addr] before any write at the same edge.
- Completion:
  - a_rvalid/a_rdata, or b_ack/b_rdata, are registered and high for exactly one cycle after the grant edge.
  - Writes complete on the same pulse as reads.
- a_overflow: a set event wins over clr_ovf in the same cycle.
- Reset values (rst_n=0 at an edge): bank=0x00 ×8, pend_v=0, last_grant=B (A wins the first tie), a_rvalid=0, a_rdata=0x00, b_ack=0, b_rdata=0x00, a_overflow=0.
- Reset mid-operation: pending entries are discarded with no completion pulse; an in-flight B request is re-arbitrated after reset.

## Timing
- Port A: strobe in cycle k → pend_v=1 in cycle k+1 → earliest grant at end of cycle k+1 → a_rvalid in cycle k+2. Latency 2 cycles uncontended, 3 when B holds the tie.
- Port B: b_req rising in cycle k → earliest b_ack in cycle k+1. With A contending: b_ack by cycle k+2.
- Worst-case wait for either port: one foreign access (round-robin guarantee).
- bank_q: reflects a write from the edge following the grant edge, aligned with the completion pulse.
- Sustained throughput: one access/cycle. Port A strobes every cycle never overflow when B is idle.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then A writes 0x5A to addr 2 (a_wen, cycle 0): a_rvalid=1, a_rdata=0x5A in cycle 2; bank_q[23:16]=0x5A. A reads addr 2 → a_rdata=0x5A.
- B read of addr 7 after reset: b_ack=1 in cycle 1, b_rdata=0x00. Holding b_req one cycle after b_ack produces no second b_ack.
- Tie after reset: A write (addr 0, 0x11) pending simultaneously with B write (addr 0, 0x22). A is granted first, B next. Final bank_q[7:0]=0x22; last_grant=B.
- Second A strobe one cycle after the first while B wins the tie: a_overflow=1, second access lost. clr_ovf → 0. clr_ovf coincident with a new overflow → stays 1.
- A strobes on 8 consecutive cycles, B idle: 8 a_rvalid pulses, no overflow. Read-during-write to the same addr returns the old value on read.
- rst_n low while pend_v=1 and b_req=1: no completion pulses, all outputs return to reset values. b_req still high after reset → b_ack one cycle after rst_n rises.
